// File: rtl/sha256_block_ctrl.sv
// rtl/sha256_block_ctrl.sv - SHA-256 per-block sequencing controller
//
// Purpose:
//   Accepts one 512-bit message block at a time, loads the message scheduler,
//   steps the scheduler and compression core through rounds 0..NUM_ROUNDS-1,
//   commands hash-state init/load/update, and offers the digest on a
//   valid/ready handshake once the last block of a message has been folded in.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   blk_valid/ready   block handshake; block_in, first_block, last_block
//                     are sampled only on an accepted handshake in IDLE
//   sched_block       registered copy of the accepted block
//   sched_load_en     one-cycle scheduler load pulse (LOAD)
//   sched_next_round  scheduler advance, high in every round but the last
//   round_idx         current round number t
//   round_en          compression core executes round round_idx
//   hash_init         load H0 into H and a..h (first block of a message)
//   hash_load         copy H into a..h (chained block)
//   hash_update       H <= H + a..h
//   digest_valid      H holds the final digest; digest_ready takes it
//   busy              controller is not in IDLE
//   blk_count         blocks completed in the current message (saturating)
//
// Every output is a register written alongside the state transition, so the
// outputs always describe the state the controller is currently in and no
// input reaches an output combinationally.

`timescale 1ns/1ps

module sha256_block_ctrl #(
  parameter int BLOCK_WIDTH = 512,
  parameter int NUM_ROUNDS  = 64,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   blk_valid,
  output logic                   blk_ready,
  input  logic [BLOCK_WIDTH-1:0] block_in,
  input  logic                   first_block,
  input  logic                   last_block,
  output logic [BLOCK_WIDTH-1:0] sched_block,
  output logic                   sched_load_en,
  output logic                   sched_next_round,
  output logic [5:0]             round_idx,
  output logic                   round_en,
  output logic                   hash_init,
  output logic                   hash_load,
  output logic                   hash_update,
  output logic                   digest_valid,
  input  logic                   digest_ready,
  output logic                   busy,
  output logic [CNT_WIDTH-1:0]   blk_count
);

  localparam logic [5:0] LAST_ROUND = 6'(NUM_ROUNDS - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ROUND,
    UPDATE,
    DONE
  } state_t;

  state_t state;
  logic   first_q;
  logic   last_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      first_q          <= 1'b0;
      last_q           <= 1'b0;
      blk_ready        <= 1'b0;
      sched_block      <= '0;
      sched_load_en    <= 1'b0;
      sched_next_round <= 1'b0;
      round_idx        <= '0;
      round_en         <= 1'b0;
      hash_init        <= 1'b0;
      hash_load        <= 1'b0;
      hash_update      <= 1'b0;
      digest_valid     <= 1'b0;
      busy             <= 1'b0;
      blk_count        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (blk_valid && blk_ready) begin
            sched_block   <= block_in;
            first_q       <= first_block;
            last_q        <= last_block;
            state         <= LOAD;
            blk_ready     <= 1'b0;
            busy          <= 1'b1;
            sched_load_en <= 1'b1;
            // A first block always restarts the chain from H0, even if the
            // previous message was never closed with last_block.
            hash_init     <= first_block;
            hash_load     <= !first_block;
          end else begin
            // Also raises blk_ready on the first clock after reset release.
            blk_ready <= 1'b1;
          end
        end

        LOAD: begin
          sched_load_en    <= 1'b0;
          hash_init        <= 1'b0;
          hash_load        <= 1'b0;
          round_idx        <= '0;
          round_en         <= 1'b1;
          sched_next_round <= (LAST_ROUND != 6'd0);
          if (first_q) begin
            blk_count <= '0;
          end
          state <= ROUND;
        end

        ROUND: begin
          if (round_idx == LAST_ROUND) begin
            // round_idx is left at the last round rather than wrapping.
            round_en         <= 1'b0;
            sched_next_round <= 1'b0;
            hash_update      <= 1'b1;
            state            <= UPDATE;
          end else begin
            round_idx        <= round_idx + 6'd1;
            // The scheduler has nothing to advance to after the last round.
            sched_next_round <= ((round_idx + 6'd1) != LAST_ROUND);
          end
        end

        UPDATE: begin
          hash_update <= 1'b0;
          if (blk_count != {CNT_WIDTH{1'b1}}) begin
            blk_count <= blk_count + 1'b1;
          end
          if (last_q) begin
            digest_valid <= 1'b1;
            state        <= DONE;
          end else begin
            busy      <= 1'b0;
            blk_ready <= 1'b1;
            state     <= IDLE;
          end
        end

        DONE: begin
          if (digest_ready) begin
            digest_valid <= 1'b0;
            busy         <= 1'b0;
            blk_ready    <= 1'b1;
            state        <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_block_ctrl.sv
// tb/tb_sha256_block_ctrl.sv - self-checking bench for sha256_block_ctrl with an attached SHA-256 datapath model

`timescale 1ns/1ps

module tb_sha256_block_ctrl;

  typedef logic [599:0] wide_t;

  localparam logic [255:0] H0 = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  localparam logic [511:0] ABC_BLK = {32'h61626380, {14{32'h00000000}}, 32'h00000018};
  localparam logic [255:0] ABC_DIG = {32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
                                      32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad};
  localparam logic [511:0] TWO_B1 = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                     32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                     32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                     32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] TWO_B2 = {{15{32'h00000000}}, 32'h000001c0};
  localparam logic [255:0] TWO_DIG = {32'h248d6a61, 32'hd20638b8, 32'he5c02693, 32'h0c3e6039,
                                      32'ha33ce459, 32'h64ff2167, 32'hf6ecedd4, 32'h19db06c1};

  logic         clk = 1'b0;
  logic         rst_n;
  logic         blk_valid;
  logic         blk_ready;
  logic [511:0] block_in;
  logic         first_block;
  logic         last_block;
  logic [511:0] sched_block;
  logic         sched_load_en;
  logic         sched_next_round;
  logic [5:0]   round_idx;
  logic         round_en;
  logic         hash_init;
  logic         hash_load;
  logic         hash_update;
  logic         digest_valid;
  logic         digest_ready;
  logic         busy;
  logic [15:0]  blk_count;

  always #5 clk = ~clk;

  sha256_block_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .block_in(block_in),
    .first_block(first_block), .last_block(last_block),
    .sched_block(sched_block), .sched_load_en(sched_load_en),
    .sched_next_round(sched_next_round), .round_idx(round_idx), .round_en(round_en),
    .hash_init(hash_init), .hash_load(hash_load), .hash_update(hash_update),
    .digest_valid(digest_valid), .digest_ready(digest_ready),
    .busy(busy), .blk_count(blk_count)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- SHA-256 arithmetic ----------------
  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction
  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction
  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction
  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [255:0] round_step(input logic [255:0] s, input logic [31:0] w,
                                              input logic [31:0] k);
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    {a, b, c, d, e, f, g, h} = s;
    t1 = h + bsig1(e) + ((e & f) ^ (~e & g)) + k + w;
    t2 = bsig0(a) + ((a & b) ^ (a & c) ^ (b & c));
    return {t1 + t2, a, b, c, d + t1, e, f, g};
  endfunction

  function automatic logic [255:0] add8(input logic [255:0] x, input logic [255:0] y);
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = x[32*i +: 32] + y[32*i +: 32];
    return r;
  endfunction

  function automatic logic [31:0] expand(input logic [31:0] w2, input logic [31:0] w7,
                                         input logic [31:0] w15, input logic [31:0] w16);
    return ssig1(w2) + w7 + ssig0(w15) + w16;
  endfunction

  // Whole-block reference compression, independent of any control signal.
  function automatic logic [255:0] sha_compress(input logic [255:0] h, input logic [511:0] blk);
    logic [31:0]  w [64];
    logic [255:0] s;
    for (int t = 0; t < 16; t++) w[t] = blk[511 - 32*t -: 32];
    for (int t = 16; t < 64; t++) w[t] = expand(w[t-2], w[t-7], w[t-15], w[t-16]);
    s = h;
    for (int t = 0; t < 64; t++) s = round_step(s, w[t], K[t]);
    return add8(h, s);
  endfunction

  // ---------------- datapath model driven by the controller's commands ----------------
  logic [255:0] hs = '0;
  logic [255:0] wv = '0;
  logic [31:0]  wm [64];
  int cyc = 0, exp_t = 0, mt = 0;
  int n_init = 0, n_hload = 0, n_round = 0, n_next = 0, n_upd = 0, seq_err = 0;
  int ld_cyc = 0, r0_cyc = 0, upd_cyc = 0, dv_cyc = 0, acc_cyc = 0;
  logic dv_prev = 1'b0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (sched_load_en) begin
      for (int i = 0; i < 16; i++) wm[i] = sched_block[511 - 32*i -: 32];
      exp_t  = 0;
      ld_cyc = cyc;
    end
    if (hash_init) begin
      hs = H0;
      wv = H0;
      n_init++;
    end
    if (hash_load) begin
      wv = hs;
      n_hload++;
    end
    if (round_en) begin
      mt = int'(round_idx);
      if (mt != exp_t) seq_err++;
      exp_t++;
      if (mt == 0) r0_cyc = cyc;
      if (mt >= 16) wm[mt] = expand(wm[mt-2], wm[mt-7], wm[mt-15], wm[mt-16]);
      wv = round_step(wv, wm[mt], K[mt]);
      n_round++;
    end
    if (sched_next_round) n_next++;
    if (hash_update) begin
      hs = add8(hs, wv);
      n_upd++;
      upd_cyc = cyc;
    end
    if (digest_valid && !dv_prev) dv_cyc = cyc;
    dv_prev = digest_valid;
  end

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input wide_t obs, input wide_t exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic wide_t outs_vec();
    return wide_t'({blk_ready, sched_block, sched_load_en, sched_next_round, round_idx,
                    round_en, hash_init, hash_load, hash_update, digest_valid, busy, blk_count});
  endfunction

  task automatic clr_counts();
    @(posedge clk);
    n_init = 0; n_hload = 0; n_round = 0; n_next = 0; n_upd = 0; seq_err = 0;
  endtask

  // Presents a block and holds it until accepted; acc_cyc marks the accept edge.
  task automatic send_block(input logic [511:0] b, input logic f, input logic l);
    logic got;
    got = 1'b0;
    @(negedge clk);
    block_in = b; first_block = f; last_block = l; blk_valid = 1'b1;
    for (int k = 0; k < 400; k++) begin
      if (blk_ready) begin
        @(posedge clk);
        acc_cyc = cyc;
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    #1;
    blk_valid = 1'b0; first_block = 1'b0; last_block = 1'b0;
    chk("accept", wide_t'(got), wide_t'(1));
  endtask

  task automatic wait_done();
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (digest_valid) break;
    end
    #1;
    chk("digest_valid_seen", wide_t'(digest_valid), wide_t'(1));
  endtask

  task automatic release_digest(input string tag);
    @(negedge clk);
    digest_ready = 1'b1;
    @(posedge clk);
    #1 digest_ready = 1'b0;
    @(negedge clk);
    chk({tag, "_idle_ready"}, wide_t'({blk_ready, digest_valid, busy}), wide_t'(3'b100));
  endtask

  task automatic check_pass(input string tag, input int nblk, input int ninit, input int nhload,
                            input int expcnt, input logic [255:0] dig);
    chk({tag, "_rounds"}, wide_t'(n_round), wide_t'(64 * nblk));
    chk({tag, "_next_pulses"}, wide_t'(n_next), wide_t'(63 * nblk));
    chk({tag, "_round_order_errs"}, wide_t'(seq_err), wide_t'(0));
    chk({tag, "_hash_init"}, wide_t'(n_init), wide_t'(ninit));
    chk({tag, "_hash_load"}, wide_t'(n_hload), wide_t'(nhload));
    chk({tag, "_updates"}, wide_t'(n_upd), wide_t'(nblk));
    chk({tag, "_blk_count"}, wide_t'(blk_count), wide_t'(expcnt));
    chk({tag, "_digest"}, wide_t'(hs), wide_t'(dig));
    chk({tag, "_lat_load"}, wide_t'(ld_cyc - acc_cyc), wide_t'(1));
    chk({tag, "_lat_round0"}, wide_t'(r0_cyc - acc_cyc), wide_t'(2));
    chk({tag, "_lat_update"}, wide_t'(upd_cyc - acc_cyc), wide_t'(66));
    chk({tag, "_lat_digest"}, wide_t'(dv_cyc - acc_cyc), wide_t'(67));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + randomized sequence ----------------
  initial begin
    int a1, nb;
    logic [511:0] rb;
    logic [255:0] hexp;

    rst_n = 1'b0; blk_valid = 1'b0; block_in = '0;
    first_block = 1'b0; last_block = 1'b0; digest_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", outs_vec(), wide_t'(0));
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_ready_busy", wide_t'({blk_ready, busy}), wide_t'(2'b10));

    // "abc": single block, then a long stall in DONE.
    clr_counts();
    send_block(ABC_BLK, 1'b1, 1'b1);
    wait_done();
    check_pass("abc", 1, 1, 0, 1, ABC_DIG);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("done_hold", wide_t'({digest_valid, blk_ready, busy}), wide_t'(3'b101));
    end
    release_digest("abc");

    // Two-block message; second block waits while the first is in flight.
    clr_counts();
    send_block(TWO_B1, 1'b1, 1'b0);
    a1 = acc_cyc;
    send_block(TWO_B2, 1'b0, 1'b1);
    chk("two_accept_gap", wide_t'(acc_cyc - a1), wide_t'(67));
    wait_done();
    check_pass("two", 2, 1, 1, 2, TWO_DIG);
    release_digest("two");

    // Reset in the middle of round 30 aborts without an update.
    clr_counts();
    send_block(ABC_BLK, 1'b1, 1'b1);
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (round_en && round_idx == 6'd30) break;
    end
    chk("reached_round30", wide_t'({round_en, round_idx}), wide_t'({1'b1, 6'd30}));
    rst_n = 1'b0;
    #1;
    chk("midrun_reset_outputs", outs_vec(), wide_t'(0));
    repeat (3) @(negedge clk);
    chk("midrun_reset_no_update", wide_t'(n_upd), wide_t'(0));
    rst_n = 1'b1;
    clr_counts();
    send_block(ABC_BLK, 1'b1, 1'b1);
    wait_done();
    check_pass("post_reset", 1, 1, 0, 1, ABC_DIG);
    release_digest("post_reset");

    // Abandoned chain: a new first block after a non-last block restarts from H0.
    clr_counts();
    send_block(TWO_B1, 1'b1, 1'b0);
    send_block(ABC_BLK, 1'b1, 1'b1);
    wait_done();
    check_pass("abandon", 2, 2, 0, 1, ABC_DIG);
    release_digest("abandon");

    // blk_valid with junk while busy must be ignored.
    clr_counts();
    send_block(ABC_BLK, 1'b1, 1'b1);
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (digest_valid) break;
      blk_valid = 1'b1;
      block_in = {16{$urandom}};
      first_block = 1'($urandom);
      last_block = 1'($urandom);
      chk("busy_sched_block_held", wide_t'(sched_block), wide_t'(ABC_BLK));
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      blk_valid = 1'b1;
      chk("done_sched_block_held", wide_t'({sched_block, blk_ready}), wide_t'({ABC_BLK, 1'b0}));
    end
    blk_valid = 1'b0; first_block = 1'b0; last_block = 1'b0;
    #1;
    check_pass("busy_pulse", 1, 1, 0, 1, ABC_DIG);
    release_digest("busy_pulse");

    // Random messages of 1..3 blocks against the whole-block reference.
    for (int m = 0; m < 4; m++) begin
      nb = int'($urandom_range(1, 3));
      hexp = H0;
      clr_counts();
      for (int b = 0; b < nb; b++) begin
        for (int i = 0; i < 16; i++) rb[32*i +: 32] = $urandom;
        hexp = sha_compress(hexp, rb);
        repeat ($urandom_range(0, 3)) @(negedge clk);
        send_block(rb, (b == 0), (b == nb - 1));
      end
      wait_done();
      check_pass("rand", nb, 1, nb - 1, nb, hexp);
      repeat ($urandom_range(0, 5)) @(negedge clk);
      release_digest("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
